// File: rtl/pwm_ctrl_pkg.sv
// pwm_ctrl_pkg: shared types and default sizing for the PWM duty-ramp controllers.
//   state_e      : controller state (IDLE, RAMP, ESTOP)
//   PWM_WIDTH    : default duty/counter width
//   RAMP_STEP    : default maximum duty change per ramp step
//   RAMP_PERIODS : default number of PWM periods per ramp step
package pwm_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RAMP  = 2'd1,
        ST_ESTOP = 2'd2
    } state_e;

    localparam int PWM_WIDTH    = 8;
    localparam int RAMP_STEP    = 4;
    localparam int RAMP_PERIODS = 2;

endpackage

// File: rtl/ramp_step.sv
// ramp_step: combinational saturating step of a value toward a target.
//   cur  : present value
//   tgt  : value being approached
//   nxt  : cur moved toward tgt by at most STEP, never overshooting or wrapping
module ramp_step #(
    parameter int WIDTH = 8,
    parameter int STEP  = 4
) (
    input  logic [WIDTH-1:0] cur,
    input  logic [WIDTH-1:0] tgt,
    output logic [WIDTH-1:0] nxt
);

    localparam logic [WIDTH-1:0] STEP_W = WIDTH'(STEP);

    logic [WIDTH-1:0] diff;

    // Direction is decided first so the subtraction is always non-negative
    // and the +/-STEP result can only be taken when it stays inside [0, tgt]
    // or [tgt, max].
    always_comb begin
        diff = '0;
        nxt  = cur;
        if (tgt > cur) begin
            diff = tgt - cur;
            nxt  = (diff <= STEP_W) ? tgt : cur + STEP_W;
        end else if (tgt < cur) begin
            diff = cur - tgt;
            nxt  = (diff <= STEP_W) ? tgt : cur - STEP_W;
        end
    end

endmodule

// File: rtl/pwm_ramp_ctrl.sv
// pwm_ramp_ctrl: soft-start/soft-stop duty controller in front of the PWM generator.
//   clk, rst     : clock, synchronous active-high reset
//   period_start : one-cycle pulse at each PWM period boundary
//   cmd_vld/cmd_duty/cmd_rdy : target duty command handshake (accepted only when idle)
//   estop        : level-sensitive emergency stop, forces duty to 0
//   duty         : live duty compare value to the PWM generator
//   ramping      : duty is slewing toward the target
//   estopped     : controller is held in emergency stop
module pwm_ramp_ctrl
    import pwm_ctrl_pkg::*;
#(
    parameter int WIDTH        = PWM_WIDTH,
    parameter int STEP         = RAMP_STEP,
    parameter int RAMP_PERIODS = pwm_ctrl_pkg::RAMP_PERIODS
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             period_start,
    input  logic             cmd_vld,
    input  logic [WIDTH-1:0] cmd_duty,
    output logic             cmd_rdy,
    input  logic             estop,
    output logic [WIDTH-1:0] duty,
    output logic             ramping,
    output logic             estopped
);

    localparam int              CW       = (RAMP_PERIODS > 1) ? $clog2(RAMP_PERIODS) : 1;
    localparam logic [CW-1:0]   CNT_LAST = CW'(RAMP_PERIODS - 1);

    state_e           state, state_nxt;
    logic [WIDTH-1:0] target, target_nxt;
    logic [WIDTH-1:0] duty_nxt;
    logic [CW-1:0]    cnt, cnt_nxt;
    logic [WIDTH-1:0] step_val;

    ramp_step #(
        .WIDTH (WIDTH),
        .STEP  (STEP)
    ) u_step (
        .cur (duty),
        .tgt (target),
        .nxt (step_val)
    );

    always_comb begin
        state_nxt  = state;
        target_nxt = target;
        duty_nxt   = duty;
        cnt_nxt    = cnt;

        if (estop) begin
            // Overrides any same-cycle accept or period boundary.
            state_nxt  = ST_ESTOP;
            target_nxt = '0;
            duty_nxt   = '0;
            cnt_nxt    = '0;
        end else begin
            unique case (state)
                ST_IDLE: begin
                    // cmd_rdy is high exactly when state is IDLE.
                    if (cmd_vld) begin
                        target_nxt = cmd_duty;
                        cnt_nxt    = '0;
                        if (cmd_duty != duty) state_nxt = ST_RAMP;
                    end
                end
                ST_RAMP: begin
                    // Duty only moves on a period boundary so the PWM never
                    // sees two compare changes within one period.
                    if (period_start) begin
                        if (cnt == CNT_LAST) begin
                            cnt_nxt  = '0;
                            duty_nxt = step_val;
                            if (step_val == target) state_nxt = ST_IDLE;
                        end else begin
                            cnt_nxt = cnt + CW'(1);
                        end
                    end
                end
                ST_ESTOP: begin
                    // Leave at duty 0; the previous target is deliberately forgotten.
                    state_nxt = ST_IDLE;
                end
                default: state_nxt = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= ST_IDLE;
            target   <= '0;
            duty     <= '0;
            cnt      <= '0;
            cmd_rdy  <= 1'b1;
            ramping  <= 1'b0;
            estopped <= 1'b0;
        end else begin
            state    <= state_nxt;
            target   <= target_nxt;
            duty     <= duty_nxt;
            cnt      <= cnt_nxt;
            // Status flags are flopped from the next state so they line up
            // with the state register without a decode after the flop.
            cmd_rdy  <= (state_nxt == ST_IDLE);
            ramping  <= (state_nxt == ST_RAMP);
            estopped <= (state_nxt == ST_ESTOP);
        end
    end

endmodule

// File: tb/tb_pwm_ramp_ctrl.sv
// tb_pwm_ramp_ctrl: directed self-checking bench for pwm_ramp_ctrl
// (WIDTH=8, STEP=4, RAMP_PERIODS=2).
module tb_pwm_ramp_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       period_start;
    logic       cmd_vld;
    logic [7:0] cmd_duty;
    logic       cmd_rdy;
    logic       estop;
    logic [7:0] duty;
    logic       ramping;
    logic       estopped;

    int n_cmp = 0;
    int n_err = 0;

    pwm_ramp_ctrl #(
        .WIDTH        (8),
        .STEP         (4),
        .RAMP_PERIODS (2)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .period_start (period_start),
        .cmd_vld      (cmd_vld),
        .cmd_duty     (cmd_duty),
        .cmd_rdy      (cmd_rdy),
        .estop        (estop),
        .duty         (duty),
        .ramping      (ramping),
        .estopped     (estopped)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", tag, act, exp);
        end
    endtask

    // Advance one clock; inputs change and outputs are sampled 1ns after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // gap-1 quiet cycles, then one cycle with period_start high.
    task automatic pulse(input int gap);
        repeat (gap - 1) tick();
        period_start = 1'b1;
        tick();
        period_start = 1'b0;
    endtask

    task automatic send(input logic [7:0] v);
        cmd_duty = v;
        cmd_vld  = 1'b1;
        tick();
        cmd_vld  = 1'b0;
    endtask

    // Pulse until the controller is idle again, bounded.
    task automatic ramp_to_idle(input string tag, input int gap, input int bound);
        int n = 0;
        while (!cmd_rdy && n < bound) begin
            pulse(gap);
            n++;
        end
        chk(tag, 32'(cmd_rdy), 1);
    endtask

    initial begin
        #1ms;
        $display("FAIL watchdog: got timeout, expected finish");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; estop = 1'b0; period_start = 1'b0; cmd_vld = 1'b0; cmd_duty = '0;
        tick(); tick();
        rst = 1'b0;
        chk("rst_duty",     32'(duty),     0);
        chk("rst_rdy",      32'(cmd_rdy),  1);
        chk("rst_ramping",  32'(ramping),  0);
        chk("rst_estopped", 32'(estopped), 0);
        repeat (3) pulse(4);
        chk("idle_pulse_duty", 32'(duty), 0);

        // Ramp up 0 -> 10 with 256-cycle periods; cmd_vld held during RAMP.
        send(8'd10);
        chk("up_ramping", 32'(ramping), 1);
        chk("up_rdy",     32'(cmd_rdy), 0);
        cmd_duty = 8'd77; cmd_vld = 1'b1;
        pulse(256); chk("up_p1", 32'(duty), 0);
        pulse(256); chk("up_p2", 32'(duty), 4);
        pulse(256); chk("up_p3", 32'(duty), 4);
        pulse(256); chk("up_p4", 32'(duty), 8);
        pulse(256); chk("up_p5", 32'(duty), 8);
        pulse(256); chk("up_p6", 32'(duty), 10);
        chk("up_done_rdy",     32'(cmd_rdy), 1);
        chk("up_done_ramping", 32'(ramping), 0);
        cmd_vld = 1'b0;
        tick();
        chk("up_no_retarget", 32'(duty), 10);

        // Ramp down 10 -> 0.
        send(8'd0);
        pulse(4); pulse(4); chk("dn_s1", 32'(duty), 6);
        pulse(4); pulse(4); chk("dn_s2", 32'(duty), 2);
        pulse(4); pulse(4); chk("dn_s3", 32'(duty), 0);
        chk("dn_rdy", 32'(cmd_rdy), 1);

        // Up to 253, then the last step to 255 must saturate, not wrap.
        send(8'd253);
        ramp_to_idle("to253_idle", 4, 200);
        chk("to253_duty", 32'(duty), 253);
        send(8'd255);
        pulse(4); pulse(4);
        chk("sat_top", 32'(duty), 255);
        chk("sat_rdy", 32'(cmd_rdy), 1);

        // Down to 8 (last step is 3, smaller than STEP).
        send(8'd8);
        ramp_to_idle("to8_idle", 4, 200);
        chk("to8_duty", 32'(duty), 8);

        // Null command.
        send(8'd8);
        chk("null_rdy",     32'(cmd_rdy), 1);
        chk("null_ramping", 32'(ramping), 0);
        pulse(4); pulse(4);
        chk("null_duty",    32'(duty),    8);
        chk("null_ramp2",   32'(ramping), 0);

        // Estop mid-ramp, coincident with period_start and cmd_vld.
        send(8'd40);
        pulse(4);
        chk("es_pre", 32'(duty), 8);
        repeat (3) tick();
        estop = 1'b1; period_start = 1'b1; cmd_vld = 1'b1; cmd_duty = 8'd50;
        tick();
        period_start = 1'b0; cmd_vld = 1'b0;
        chk("es_duty",     32'(duty),     0);
        chk("es_estopped", 32'(estopped), 1);
        chk("es_rdy",      32'(cmd_rdy),  0);
        chk("es_ramping",  32'(ramping),  0);
        pulse(4);
        chk("es_hold", 32'(duty), 0);
        estop = 1'b0;
        tick();
        chk("es_rel_estopped", 32'(estopped), 0);
        chk("es_rel_rdy",      32'(cmd_rdy),  1);
        pulse(4); pulse(4);
        chk("es_rel_duty", 32'(duty), 0);

        // Reset mid-ramp.
        send(8'd100);
        repeat (6) pulse(4);
        chk("rm_pre", 32'(duty), 12);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("rm_duty",    32'(duty),    0);
        chk("rm_rdy",     32'(cmd_rdy), 1);
        chk("rm_ramping", 32'(ramping), 0);
        send(8'd4);
        pulse(4);
        chk("rm_c1", 32'(duty), 0);
        pulse(4);
        chk("rm_c2",   32'(duty),    4);
        chk("rm_rdy2", 32'(cmd_rdy), 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
